datamem_responder: RTL and testbench



---
 rtl/datamem_pkg.sv | 21 ++
 rtl/datamem_responder_byte_lane_mem.sv | 29 ++
 rtl/datamem_responder.sv | 130 +++++++++++++
 tb/tb_datamem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// Shared types and helpers for the data-memory responder.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

  // Only power-of-two byte counts up to a doubleword are legal.
  function automatic logic legal_size(input logic [3:0] size);
    return (size == XFER_B) || (size == XFER_H) ||
           (size == XFER_W) || (size == XFER_D);
  endfunction

endpackage

// File: rtl/datamem_responder_byte_lane_mem.sv
// Byte-addressable storage with eight byte-lane write enables and an
// eight-byte read window starting at the base address. No reset: contents
// survive a responder reset.
module byte_lane_mem #(
  parameter int DEPTH_BYTES = 64
) (
  input  logic                           i_clk,
  input  logic [7:0]                     i_we,
  input  logic [$clog2(DEPTH_BYTES)-1:0] i_addr,
  input  logic [63:0]                    i_wdata,
  output logic [63:0]                    o_rdata
);
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] r_mem [DEPTH_BYTES];

  // Lane i writes byte i of the data to base+i (little-endian).
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 8; i++) begin
      if (i_we[i]) r_mem[i_addr + AW'(i)] <= i_wdata[8*i +: 8];
    end
  end

  // Read window wraps inside the array; lanes past the size are masked upstream.
  for (genvar g = 0; g < 8; g++) begin : g_rd
    assign o_rdata[8*g +: 8] = r_mem[i_addr + AW'(g)];
  end

endmodule

// File: rtl/datamem_responder.sv
// Data-memory responder: one request in flight, sized little-endian access
// after WAIT_STATES cycles, registered response held until taken.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [3:0]  i_req_xfer_size,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err
);
  localparam int AW        = $clog2(DEPTH_BYTES);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  dm_state_t r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;
  logic [3:0]    r_size;
  logic          r_err;
  logic [63:0]   r_resp_rdata;
  logic          r_resp_err;

  logic          w_accept, w_req_err, w_access;
  logic          w_a_write, w_a_err;
  logic [AW-1:0] w_a_addr;
  logic [63:0]   w_a_wdata;
  logic [3:0]    w_a_size;
  logic [7:0]    w_lane_en, w_we;
  logic [63:0]   w_mem_rdata, w_load_data;

  assign w_accept = i_req_valid & o_req_ready;

  // Alignment test is only meaningful for legal sizes; the OR covers the rest.
  // Aligned and in-array implies addr+size <= DEPTH_BYTES since size <= 8.
  assign w_req_err = !legal_size(i_req_xfer_size) ||
                     (|(i_req_addr[3:0] & (i_req_xfer_size - 4'd1))) ||
                     (|i_req_addr[63:AW]);

  // With no wait states the access uses the request inputs on the accept
  // edge; otherwise it uses the latched request on the last WAIT edge.
  assign w_access  = ZERO_WAIT ? w_accept : (r_state == WAIT && r_cnt == 4'd1);
  assign w_a_write = ZERO_WAIT ? i_req_write          : r_write;
  assign w_a_addr  = ZERO_WAIT ? i_req_addr[AW-1:0]   : r_addr;
  assign w_a_wdata = ZERO_WAIT ? i_req_wdata          : r_wdata;
  assign w_a_size  = ZERO_WAIT ? i_req_xfer_size      : r_size;
  assign w_a_err   = ZERO_WAIT ? w_req_err            : r_err;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign w_lane_en[g]          = (4'(g) < w_a_size);
    assign w_load_data[8*g +: 8] = w_lane_en[g] ? w_mem_rdata[8*g +: 8] : 8'h00;
  end

  assign w_we = (w_access && w_a_write && !w_a_err) ? w_lane_en : 8'h00;

  byte_lane_mem #(.DEPTH_BYTES(DEPTH_BYTES)) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_a_addr),
    .i_wdata (w_a_wdata),
    .o_rdata (w_mem_rdata)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ZERO_WAIT ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    if (i_resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    o_req_ready  = (r_state == IDLE);
    o_resp_valid = (r_state == RESP);
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_err        <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr[AW-1:0];
        r_wdata <= i_req_wdata;
        r_size  <= i_req_xfer_size;
        r_err   <= w_req_err;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_resp_err   <= w_a_err;
        r_resp_rdata <= (w_a_write || w_a_err) ? 64'h0 : w_load_data;
      end
    end
  end

  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench: main instance with two wait states, second instance with
// none for the back-to-back throughput case.
module tb_datamem_responder;
  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_write, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  logic        z_req_valid, z_req_write, z_resp_ready;
  logic [63:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_size;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [63:0] z_resp_rdata;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_BYTES(64), .WAIT_STATES(2)) u_dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_xfer_size(req_size),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err)
  );

  datamem_responder #(.DEPTH_BYTES(64), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_valid(z_req_valid), .o_req_ready(z_req_ready), .i_req_write(z_req_write),
    .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata), .i_req_xfer_size(z_req_size),
    .o_resp_valid(z_resp_valid), .i_resp_ready(z_resp_ready),
    .o_resp_rdata(z_resp_rdata), .o_resp_err(z_resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // One full transaction on the main instance; lat = edges from accept to resp_valid.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     input logic [3:0] sz, output logic [63:0] rd, output logic er,
                     output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = sz;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) chk("resp_timeout", 64'd0, 64'd1);
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [63:0] a, input logic [3:0] sz,
                    input logic [63:0] exp_d, input logic exp_e);
    logic [63:0] rd; logic er; int lat;
    txn(1'b0, a, 64'h0, sz, rd, er, lat);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, {63'd0, er}, {63'd0, exp_e});
  endtask

  task automatic st(input string tag, input logic [63:0] a, input logic [63:0] d,
                    input logic [3:0] sz, input logic exp_e);
    logic [63:0] rd; logic er; int lat;
    txn(1'b1, a, d, sz, rd, er, lat);
    chk({tag, "_data"}, rd, 64'h0);
    chk({tag, "_err"}, {63'd0, er}, {63'd0, exp_e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, snap;
    logic er;
    int lat, wcnt;
    logic        zw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] za [4] = '{64'h08, 64'h08, 64'h0A, 64'h08};
    logic [63:0] zd [4] = '{64'h0102030405060708, 64'h0, 64'h000000000000BEEF, 64'h0};
    logic [3:0]  zs [4] = '{4'd8, 4'd8, 4'd2, 4'd4};
    logic [63:0] ze [4] = '{64'h0, 64'h0102030405060708, 64'h0, 64'h00000000BEEF0708};

    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_size = 0;
    z_resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic store/load and latency.
    st("st8", 64'h10, 64'h1122334455667788, 4'd8, 1'b0);
    txn(1'b0, 64'h10, 64'h0, 4'd8, rd, er, lat);
    chk("ld8_data", rd, 64'h1122334455667788);
    chk("ld8_err", {63'd0, er}, 64'd0);
    chk("ld8_latency", 64'(lat), 64'd2);

    // Sized loads.
    ld("ld1", 64'h13, 4'd1, 64'h55, 1'b0);
    ld("ld2", 64'h12, 4'd2, 64'h5566, 1'b0);
    ld("ld4", 64'h14, 4'd4, 64'h11223344, 1'b0);
    st("st1", 64'h10, 64'hDEADBEEFCAFE00AB, 4'd1, 1'b0);
    ld("ld8b", 64'h10, 4'd8, 64'h11223344556677AB, 1'b0);

    // Errors, then memory unchanged.
    ld("mis4", 64'h12, 4'd4, 64'h0, 1'b1);
    st("sz3", 64'h10, 64'hFFFFFFFFFFFFFFFF, 4'd3, 1'b1);
    st("oor8", 64'h40, 64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b1);
    ld("hiaddr", 64'h8000000000000010, 4'd1, 64'h0, 1'b1);
    ld("ld_after_err", 64'h10, 4'd8, 64'h11223344556677AB, 1'b0);
    st("edge_st", 64'h38, 64'h0807060504030201, 4'd8, 1'b0);
    ld("edge_ld", 64'h3F, 4'd1, 64'h08, 1'b0);

    // Backpressure: response frozen, stray request ignored.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wcnt = 0;
    while (!resp_valid && wcnt < 20) begin @(posedge clk); #1; wcnt++; end
    snap = resp_rdata;
    chk("bp_data", snap, 64'h11223344556677AB);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h0; req_size = 4'd8;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_hold", resp_rdata, snap);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_idle_valid", {63'd0, resp_valid}, 64'd0);
    ld("bp_reload", 64'h10, 4'd8, 64'h11223344556677AB, 1'b0);

    // Zero wait states, back-to-back with resp_ready tied high.
    chk("z_ready0", {63'd0, z_req_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      z_req_valid = 1'b1; z_req_write = zw[k]; z_req_addr = za[k];
      z_req_wdata = zd[k]; z_req_size = zs[k];
      @(posedge clk); #1;
      chk($sformatf("z%0d_valid", k), {63'd0, z_resp_valid}, 64'd1);
      chk($sformatf("z%0d_ready", k), {63'd0, z_req_ready}, 64'd0);
      chk($sformatf("z%0d_data", k), z_resp_rdata, ze[k]);
      chk($sformatf("z%0d_err", k), {63'd0, z_resp_err}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("z%0d_back", k), {63'd0, z_req_ready}, 64'd1);
    end
    z_req_valid = 1'b0;

    // Reset during WAIT drops the pending store.
    st("pre0", 64'h20, 64'h00, 4'd1, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hFF; req_size = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_busy", {63'd0, req_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_rst_ready2", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_valid2", {63'd0, resp_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ld("mid_reload", 64'h20, 4'd1, 64'h00, 1'b0);
    ld("persist", 64'h10, 4'd8, 64'h11223344556677AB, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
